// File: rtl/imm_inst_encoder_pkg.sv
// Shared opcodes, state/form enums and RV64I field-assembly helpers for the
// constant-materialisation encoder.
package imm_enc_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {IDLE, EMIT} state_t;

  typedef enum logic [2:0] {F_NOP, F_I12, F_LUI, F_LUIW, F_LONG} form_t;

  function automatic logic [3:0] form_len(form_t f);
    case (f)
      F_LUIW:  return 4'd2;
      F_LONG:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [31:0] i_type(logic [11:0] imm12, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] u_type(logic [19:0] imm20, logic [4:0] rd);
    return {imm20, rd, OP_LUI};
  endfunction

  // Rounded upper 20 bits so that a following sign-extended lo12 lands exactly.
  function automatic logic [19:0] hi20(logic [31:0] v);
    logic [31:0] s;
    s = v + 32'h0000_0800;
    return s[31:12];
  endfunction

  function automatic form_t select_form(logic [4:0] rd, logic [63:0] imm);
    if (rd == 5'd0)                             return F_NOP;
    else if ((&imm[63:11]) || !(|imm[63:11]))   return F_I12;
    else if ((&imm[63:31]) || !(|imm[63:31]))   return (imm[11:0] == 12'd0) ? F_LUI : F_LUIW;
    else                                        return F_LONG;
  endfunction

endpackage

// File: rtl/imm_inst_encoder_if.sv
// Request and instruction-stream handshake bundle for the encoder.
interface imm_inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [63:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        busy;

  modport master (output req_valid, req_rd, req_imm, out_ready,
                  input  req_ready, out_valid, out_inst, out_last, busy);
  modport slave  (input  req_valid, req_rd, req_imm, out_ready,
                  output req_ready, out_valid, out_inst, out_last, busy);
endinterface

// File: rtl/imm_inst_encoder_inst_field_pack.sv
// Combinational assembly of the instruction word for a given form and step.
module inst_field_pack
  import imm_enc_pkg::*;
(
  input  form_t       form,
  input  logic [2:0]  step,
  input  logic [4:0]  rd,
  input  logic [63:0] imm,
  output logic [31:0] inst
);

  always_comb begin
    inst = NOP_INST;
    case (form)
      F_I12: inst = i_type(imm[11:0], 5'd0, F3_ADD, rd, OP_IMM);
      F_LUI, F_LUIW:
        inst = (step == 3'd0) ? u_type(hi20(imm[31:0]), rd)
                              : i_type(imm[11:0], rd, F3_ADD, rd, OP_IMM32);
      // Upper word via LUI/ADDIW, then three shift-and-add rounds of 11/11/10 bits.
      F_LONG: begin
        case (step)
          3'd0:       inst = u_type(hi20(imm[63:32]), rd);
          3'd1:       inst = i_type(imm[43:32], rd, F3_ADD, rd, OP_IMM32);
          3'd2, 3'd4: inst = i_type(12'd11, rd, F3_SLL, rd, OP_IMM);
          3'd3:       inst = i_type({1'b0, imm[31:21]}, rd, F3_ADD, rd, OP_IMM);
          3'd5:       inst = i_type({1'b0, imm[20:10]}, rd, F3_ADD, rd, OP_IMM);
          3'd6:       inst = i_type(12'd10, rd, F3_SLL, rd, OP_IMM);
          default:    inst = i_type({2'b0, imm[9:0]}, rd, F3_ADD, rd, OP_IMM);
        endcase
      end
      default: inst = NOP_INST;
    endcase
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// Emits the minimal LUI/ADDI/ADDIW/SLLI sequence that loads a 64-bit constant
// into rd, one registered word per output handshake.
module imm_inst_encoder
  import imm_enc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  imm_inst_encoder_if.slave bus
);

  state_t      state_q, state_d;
  form_t       form_q, form_d;
  logic [2:0]  step_q, step_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] imm_q, imm_d;
  logic        load;
  logic [31:0] inst_d, out_inst_q;
  logic        out_last_q;

  // Packs the word for the step about to be presented, so the output is registered.
  inst_field_pack u_pack (
    .form (form_d),
    .step (step_d),
    .rd   (rd_d),
    .imm  (imm_d),
    .inst (inst_d)
  );

  always_comb begin
    state_d = state_q;
    form_d  = form_q;
    step_d  = step_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = EMIT;
          form_d  = select_form(bus.req_rd, bus.req_imm);
          step_d  = 3'd0;
          rd_d    = bus.req_rd;
          imm_d   = bus.req_imm;
          load    = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d = IDLE;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      form_q     <= F_NOP;
      step_q     <= 3'd0;
      rd_q       <= 5'd0;
      imm_q      <= 64'd0;
      out_inst_q <= 32'd0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      form_q  <= form_d;
      step_q  <= step_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      if (load) begin
        out_inst_q <= inst_d;
        out_last_q <= ({1'b0, step_d} == (form_len(form_d) - 4'd1));
      end else if (state_d == IDLE) begin
        out_inst_q <= 32'd0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == EMIT);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_inst  = out_inst_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench: arithmetic reference model plus an executor that replays
// the emitted words and confirms the register ends up holding the constant.
module tb_imm_inst_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_inst_encoder_if bus ();
  imm_inst_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(longint imm12, int rs1, int f3, int rd, int op);
    return (32'(imm12 & 'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
           (32'(rd) << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] enc_u(longint imm20, int rd);
    return (32'(imm20 & 'hFFFFF) << 12) | (32'(rd) << 7) | 32'h37;
  endfunction

  // Reference: choose the shortest form from the numeric range of the value.
  function automatic void build(input logic [4:0] rd, input logic [63:0] imm);
    longint s, v, hi, lo;
    int r;
    s = longint'(imm);
    r = int'(rd);
    exp_q.delete();
    if (r == 0) exp_q.push_back(32'h13);
    else if (s >= -2048 && s <= 2047) exp_q.push_back(enc_i(s, 0, 0, r, 'h13));
    else if (s >= -(longint'(1) <<< 31) && s < (longint'(1) <<< 31)) begin
      lo = s & 'hFFF;
      hi = ((s + 'h800) >>> 12) & 'hFFFFF;
      exp_q.push_back(enc_u(hi, r));
      if (lo != 0) exp_q.push_back(enc_i(lo, r, 0, r, 'h1B));
    end else begin
      v  = s >>> 32;
      hi = ((v + 'h800) >>> 12) & 'hFFFFF;
      exp_q.push_back(enc_u(hi, r));
      exp_q.push_back(enc_i(v & 'hFFF, r, 0, r, 'h1B));
      exp_q.push_back(enc_i(11, r, 1, r, 'h13));
      exp_q.push_back(enc_i((s >> 21) & 'h7FF, r, 0, r, 'h13));
      exp_q.push_back(enc_i(11, r, 1, r, 'h13));
      exp_q.push_back(enc_i((s >> 10) & 'h7FF, r, 0, r, 'h13));
      exp_q.push_back(enc_i(10, r, 1, r, 'h13));
      exp_q.push_back(enc_i(s & 'h3FF, r, 0, r, 'h13));
    end
  endfunction

  function automatic logic [63:0] sx12(logic [11:0] x);
    return {{52{x[11]}}, x};
  endfunction

  function automatic logic [63:0] sx32(logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Executes the captured words with RV64I semantics on one register.
  function automatic logic [63:0] execute();
    logic [63:0] r;
    logic [31:0] w, t;
    r = 64'd0;
    foreach (got_q[i]) begin
      w = got_q[i];
      if (w[6:0] == 7'b0110111) r = sx32({w[31:12], 12'd0});
      else if (w[6:0] == 7'b0011011) begin
        t = r[31:0] + w[31:20] + {{20{w[31]}}, 12'd0};
        r = sx32(t);
      end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b001) r = r << w[25:20];
      else if (w[6:0] == 7'b0010011) r = r + sx12(w[31:20]);
      else r = 64'hDEAD_DEAD_DEAD_DEAD;
    end
    return r;
  endfunction

  task automatic do_seq(input logic [4:0] rd, input logic [63:0] imm,
                        input int stall_at, input int stall_n);
    int n;
    logic [63:0] res;
    build(rd, imm);
    n = exp_q.size();
    got_q.delete();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL pre_ready: got %b want 1", bus.req_ready);
    end
    bus.req_rd = rd; bus.req_imm = imm; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_rd = 5'($urandom);
    bus.req_imm = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_inst !== exp_q[i] ||
              bus.out_last !== (i == n - 1) || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold step %0d: v=%b inst=%h last=%b rdy=%b want v=1 inst=%h last=%b rdy=0",
                     i, bus.out_valid, bus.out_inst, bus.out_last, bus.req_ready, exp_q[i], (i == n - 1));
          end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_inst !== exp_q[i] ||
          bus.out_last !== (i == n - 1) || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL word rd=%0d imm=%h step %0d: v=%b inst=%h last=%b rdy=%b busy=%b want v=1 inst=%h last=%b rdy=0 busy=1",
                 rd, imm, i, bus.out_valid, bus.out_inst, bus.out_last, bus.req_ready, bus.busy,
                 exp_q[i], (i == n - 1));
      end
      got_q.push_back(bus.out_inst);
      @(posedge clk); #1;
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL post_idle: rdy=%b v=%b busy=%b want 1 0 0", bus.req_ready, bus.out_valid, bus.busy);
    end
    if (rd != 5'd0) begin
      res = execute();
      checks++;
      if (res !== imm) begin
        failures++; $display("FAIL exec rd=%0d: got %h want %h", rd, res, imm);
      end
    end
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] want);
    checks++;
    if (got_q.size() <= idx || got_q[idx] !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, (got_q.size() > idx) ? got_q[idx] : 32'hx, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_rd = 5'd0; bus.req_imm = 64'd0; bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_inst !== 32'd0 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b v=%b inst=%h last=%b busy=%b", bus.req_ready,
               bus.out_valid, bus.out_inst, bus.out_last, bus.busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_seq(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
    chk_word("addi_m1", 0, 32'hFFF00293);
    do_seq(5'd10, 64'h1234_5678, -1, 0);
    chk_word("lui_w0", 0, 32'h12345537);
    chk_word("addiw_w1", 1, 32'h6785051B);
    do_seq(5'd1, 64'h1000, -1, 0);
    chk_word("lui_only", 0, 32'h000010B7);
    do_seq(5'd0, {$urandom, $urandom}, -1, 0);
    chk_word("nop", 0, 32'h00000013);
    do_seq(5'd3, 64'h0000_0001_0000_0000, -1, 0);
    chk_word("long_lui", 0, 32'h000001B7);
    chk_word("long_addiw", 1, 32'h0011819B);
    chk_word("long_slli", 2, 32'h00B19193);
    chk_word("long_last", 7, 32'h00018193);
  endtask

  task automatic test_stall();
    do_seq(5'($urandom_range(1, 31)), 64'h8765_4321_0FED_CBA9, 4, 3);
  endtask

  task automatic test_reset_abort();
    bus.req_rd = 5'd7; bus.req_imm = 64'h1234_5678_9ABC_DEF0;
    bus.req_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL abort_pre: v=%b busy=%b want 1 1", bus.out_valid, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_inst !== 32'd0 || bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: v=%b rdy=%b busy=%b inst=%h last=%b", bus.out_valid,
               bus.req_ready, bus.busy, bus.out_inst, bus.out_last);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_seq(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
    chk_word("after_abort", 0, 32'hFFF00293);
  endtask

  task automatic test_random();
    logic [63:0] edges [10];
    logic [63:0] imm;
    edges = '{64'd2047, 64'hFFFF_FFFF_FFFF_F800, 64'd2048, 64'hFFFF_FFFF_FFFF_F7FF,
              64'h7FFF_F800, 64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
              64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 4))
        0: imm = sx12(12'($urandom));
        1: imm = sx32($urandom);
        2: imm = sx32({$urandom_range(0, 32'hFFFFF), 12'd0});
        3: imm = {$urandom, $urandom};
        default: imm = edges[$urandom_range(0, 9)];
      endcase
      do_seq(5'($urandom_range(0, 31)), imm, $urandom_range(0, 7), $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    do_seq(5'd9, 64'hFEDC_BA98_7654_3210, -1, 0);
    do_seq(5'd9, 64'h0000_7FFF_FFFF_F000, -1, 0);
    do_seq(5'd31, 64'hFFFF_FFFF_FFFF_F800, -1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
